// File: rtl/bp_sacc_spm_arbiter.sv
// Round-robin arbiter that shares one 1rw scratchpad SRAM between an IO-command requester (0)
// and the accelerator engine (1), with one registered response slot per requester.
module bp_sacc_spm_arbiter #(
  parameter int unsigned els_p        = 20,
  parameter int unsigned data_width_p = 64,
  parameter int unsigned addr_width_p = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int unsigned cnt_width_p  = 10
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,

  input  logic [1:0]                req_v_i,
  input  logic [1:0]                req_w_i,
  input  logic [2*addr_width_p-1:0] req_addr_i,
  input  logic [2*data_width_p-1:0] req_data_i,
  output logic [1:0]                req_ready_and_o,

  output logic [1:0]                resp_v_o,
  output logic [2*data_width_p-1:0] resp_data_o,
  output logic [1:0]                resp_err_o,
  input  logic [1:0]                resp_ready_and_i,

  output logic                      mem_v_o,
  output logic                      mem_w_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  input  logic [data_width_p-1:0]   mem_data_i,

  input  logic                      wr_cnt_clear_i,
  output logic [cnt_width_p-1:0]    wr_cnt_o
);

  typedef enum logic [1:0] {StEmpty, StInflight, StFull} slot_e;

  slot_e                    slot_q [2];
  slot_e                    slot_d [2];
  logic [1:0]               rd_pend_q;
  logic [1:0]               err_pend_q;
  logic [data_width_p-1:0]  resp_data_q [2];
  logic [1:0]               resp_err_q;
  logic                     last_grant_q;
  logic [cnt_width_p-1:0]   wr_cnt_q, wr_cnt_d;

  logic [addr_width_p-1:0]  req_addr [2];
  logic [1:0]               in_range;
  logic [1:0]               resp_hs;
  logic [1:0]               eligible;
  logic [1:0]               grant;
  logic                     gnt_sel;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = req_addr_i[i*addr_width_p +: addr_width_p];
      in_range[i] = (32'(req_addr[i]) < els_p);
      resp_hs[i]  = (slot_q[i] == StFull) & resp_ready_and_i[i];
      // A full slot can take a new request in the same cycle its response drains.
      eligible[i] = req_v_i[i] & ((slot_q[i] == StEmpty) | resp_hs[i]);
    end
  end

  always_comb begin
    grant = 2'b00;
    if (reset_n_i) begin
      unique case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_sel         = grant[1];
  assign req_ready_and_o = grant;

  assign mem_v_o    = (|grant) & in_range[gnt_sel];
  assign mem_w_o    = (|grant) & req_w_i[gnt_sel];
  assign mem_addr_o = req_addr[gnt_sel];
  assign mem_data_o = gnt_sel ? req_data_i[data_width_p +: data_width_p]
                              : req_data_i[0 +: data_width_p];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slot_d[i] = slot_q[i];
      unique case (slot_q[i])
        StEmpty:    if (grant[i]) slot_d[i] = StInflight;
        StInflight: slot_d[i] = StFull;
        StFull:     if (resp_hs[i]) slot_d[i] = grant[i] ? StInflight : StEmpty;
        default:    slot_d[i] = StEmpty;
      endcase
    end
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (wr_cnt_clear_i) begin
      wr_cnt_d = '0;
    end else if (mem_v_o && mem_w_o && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + cnt_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i]      <= StEmpty;
        resp_data_q[i] <= '0;
      end
      rd_pend_q    <= '0;
      err_pend_q   <= '0;
      resp_err_q   <= '0;
      last_grant_q <= 1'b1;
      wr_cnt_q     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= slot_d[i];
        if (grant[i]) begin
          rd_pend_q[i]  <= ~req_w_i[i] & in_range[i];
          err_pend_q[i] <= ~in_range[i];
        end
        // SRAM read data is valid exactly while the slot is in flight.
        if (slot_q[i] == StInflight) begin
          resp_data_q[i] <= rd_pend_q[i] ? mem_data_i : '0;
          resp_err_q[i]  <= err_pend_q[i];
        end
      end
      if (|grant) last_grant_q <= gnt_sel;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      resp_v_o[i] = (slot_q[i] == StFull);
    end
  end

  assign resp_data_o = {resp_data_q[1], resp_data_q[0]};
  assign resp_err_o  = resp_err_q;
  assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: doc/bp_sacc_spm_arbiter.md
Name: bp_sacc_spm_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one single-port synchronous scratchpad SRAM (1rw, 1-cycle read latency) between two requesters.
- Requester 0 is the MMIO/IO-command path; requester 1 is the accelerator compute engine.
- Each request gets exactly one response through a per-requester response register. The block also keeps a saturating count of in-range writes for CSR readback.

Parameters:
- els_p, 20, number of SRAM words.
- data_width_p, 64, word width in bits.
- addr_width_p, `BSG_SAFE_CLOG2(els_p), word address width.
- cnt_width_p, 10, width of the write counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- req_v_i  in  2  request valid, one bit per requester.
- req_w_i  in  2  1 = write, 0 = read.
- req_addr_i  in  2*addr_width_p  word address; requester i occupies slice i.
- req_data_i  in  2*data_width_p  write data.
- req_ready_and_o  out  2  request accepted when v & ready_and.
- resp_v_o  out  2  response valid.
- resp_data_o  out  2*data_width_p  read data; 0 for writes and errors.
- resp_err_o  out  2  address was out of range (addr >= els_p).
- resp_ready_and_i  in  2  response consumed when v & ready_and.
- mem_v_o  out  1  SRAM enable.
- mem_w_o  out  1  SRAM write enable.
- mem_addr_o  out  addr_width_p  SRAM address.
- mem_data_o  out  data_width_p  SRAM write data.
- mem_data_i  in  data_width_p  SRAM read data, valid the cycle after a read.
- wr_cnt_clear_i  in  1  synchronous clear of the write counter.
- wr_cnt_o  out  cnt_width_p  write count.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - both slots go to EMPTY; last_grant is set to 1, so requester 0 wins first.
  - resp_v_o=0, resp_data_o=0, resp_err_o=0, wr_cnt_o=0.
  - mem_v_o=0 and req_ready_and_o=0 while reset is asserted.
  - Reset mid-operation discards any in-flight or held response without emitting it.
- Per-requester slot FSM, states EMPTY, INFLIGHT, FULL:
  - EMPTY -> INFLIGHT on grant.
  - INFLIGHT -> FULL unconditionally the next cycle. On that edge resp_data captures mem_data_i (reads, in range) or 0, and resp_err captures the range check.
  - FULL -> EMPTY on resp handshake.
  - FULL with handshake and a same-cycle grant -> INFLIGHT.
- Eligibility: requester i is eligible when req_v_i[i] is high and slot i is either EMPTY, or FULL with resp_ready_and_i[i] high this cycle. An INFLIGHT slot is never eligible.
- Arbitration, combinational, at most one grant per cycle:
  - If one requester is eligible, it is granted.
  - If both are eligible, the one != last_grant is granted.
  - last_grant updates only on a grant.
  - req_ready_and_o[i] = grant[i]. ready does not depend on the other requester's response state.
- SRAM drive:
  - mem_v_o = grant & in_range; mem_w_o = req_w of the granted requester.
  - mem_addr_o and mem_data_o come from the granted requester.
  - Out-of-range requests are granted and complete normally with resp_err=1 and data 0, but never touch the SRAM.
- Latency: grant in cycle t -> SRAM access at edge t -> resp_v_o high from cycle t+2.
  - Peak throughput is 1 grant/cycle with both requesters active (alternating), and 1 grant per 2 cycles with a single requester.
- resp_v_o and resp_data_o are registered and held stable until the handshake. There is no combinational path from req_* to resp_*.
- Write counter:
  - Increments by 1 on each granted in-range write and saturates at 2^cnt_width_p-1.
  - wr_cnt_clear_i wins over a same-cycle increment, giving a result of 0.
  - Reads and out-of-range writes do not count.

Test Plan:
- Reset then idle: release reset_n_i with no requests -> all outputs 0, mem_v_o=0 for 10 cycles; assert reset asynchronously mid-cycle with slot 1 FULL -> resp_v_o[1] drops immediately.
- Single write/read: req0 writes addr 5 = 0xDEADBEEF_CAFEF00D, then reads addr 5 -> write resp at t+2 with data 0, err 0; read resp data 0xDEADBEEF_CAFEF00D at t+2 of the read; wr_cnt_o=1.
- Contention: both requesters hold reads continuously from reset with resp_ready_and_i=11 -> grants alternate 0,1,0,1; mem_v_o high every cycle; each requester gets one response per 2 cycles.
- Backpressure: resp_ready_and_i[1]=0 with slot 1 FULL -> req_ready_and_o[1]=0 and requester 0 gets every eligible grant; raise ready -> handshake and new grant to requester 1 in the same cycle.
- Out of range: req1 writes addr 20 (els_p=20) -> mem_v_o=0, resp_err_o[1]=1, resp_data 0, wr_cnt_o unchanged.
- Counter bounds: 1023 writes then 1 more -> wr_cnt_o=1023; a write concurrent with wr_cnt_clear_i -> 0; next write -> 1.
